// File: rtl/board_io_ctrl_if.sv
// J1 I/O bus: CPU-side address/write data/strobes and the slave read-data return path.
interface if_io;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] din;
    logic        rd;
    logic        wr;

    modport slave  (input addr, dout, rd, wr, output din);
    modport master (output addr, dout, rd, wr, input din);
endinterface

// File: rtl/board_io_ctrl.sv
// Evaluation-board I/O peripheral: LEDs, synchronised switches, debounced keys with events/IRQ, 7-seg digits.
// Optional hex-nibble decode for digit writes is enabled by defining BOARD_IO_CTRL_HEXDEC_EN.
module board_io_ctrl #(
    parameter logic [15:0] BASE            = 16'h0000,
    parameter int          NUM_LEDG        = 8,
    parameter int          NUM_LEDR        = 10,
    parameter int          NUM_SW          = 10,
    parameter int          NUM_KEY         = 4,
    parameter int          NUM_HEX         = 4,
    parameter int          DEBOUNCE_CYCLES = 500000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_KEY-1:0]        key,
    input  logic [NUM_SW-1:0]         sw,
    output logic [0:NUM_HEX-1][6:0]   hex,
    output logic [NUM_LEDG-1:0]       ledg,
    output logic [NUM_LEDR-1:0]       ledr,
    output logic                      irq,
    if_io.slave                       io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_LEDG-1:0]           ledg_q, ledg_d;
    logic [NUM_LEDR-1:0]           ledr_q, ledr_d;
    logic [NUM_KEY-1:0]            ksync1_q, ksync2_q;
    logic [NUM_SW-1:0]             swsync1_q, swsync2_q;
    logic [NUM_KEY-1:0]            kstable_q, kstable_d;   // raw level, 0 = pressed
    logic [NUM_KEY-1:0][CW-1:0]    cnt_q, cnt_d;
    logic [NUM_KEY-1:0]            evt_q, evt_d, evt_set, evt_clr;
    logic [NUM_KEY-1:0]            mask_q, mask_d;
    logic [0:NUM_HEX-1][6:0]       hex_q, hex_d;
    logic [15:0]                   off;
    logic [15:0]                   rdata;
    logic                          unused_dout;

`ifdef BOARD_IO_CTRL_HEXDEC_EN
    logic [NUM_HEX-1:0]            hexmode_q, hexmode_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction
`endif

    // Bus protocol: rd selects combinational read data this cycle; wr commits at the next clk edge.
    // With both asserted, the read returns the pre-write contents.
    assign off         = io.addr - BASE;
    assign unused_dout = ^io.dout;

    always_comb begin
        ledg_d    = ledg_q;
        ledr_d    = ledr_q;
        mask_d    = mask_q;
        hex_d     = hex_q;
        kstable_d = kstable_q;
        cnt_d     = cnt_q;
        evt_set   = '0;
        evt_clr   = '0;
`ifdef BOARD_IO_CTRL_HEXDEC_EN
        hexmode_d = hexmode_q;
`endif
        for (int i = 0; i < NUM_KEY; i++) begin
            if (ksync2_q[i] == kstable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                kstable_d[i] = ksync2_q[i];
                cnt_d[i]     = '0;
                evt_set[i]   = ~ksync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        if (io.wr) begin
            case (off)
                16'd0: ledg_d  = io.dout[NUM_LEDG-1:0];
                16'd1: ledr_d  = io.dout[NUM_LEDR-1:0];
                16'd3: evt_clr = io.dout[NUM_KEY-1:0];
                16'd4: mask_d  = io.dout[NUM_KEY-1:0];
`ifdef BOARD_IO_CTRL_HEXDEC_EN
                16'd6: hexmode_d = io.dout[NUM_HEX-1:0];
`endif
                default: ;
            endcase
            for (int i = 0; i < NUM_HEX; i++) begin
                if (off == 16'(8 + i)) begin
`ifdef BOARD_IO_CTRL_HEXDEC_EN
                    hex_d[i] = hexmode_q[i] ? ~seg7(io.dout[3:0]) : ~io.dout[6:0];
`else
                    hex_d[i] = ~io.dout[6:0];
`endif
                end
            end
        end
        // A new press on the same edge as a W1C keeps the event pending.
        evt_d = (evt_q & ~evt_clr) | evt_set;
    end

    always_comb begin
        rdata = '0;
        if (io.rd) begin
            case (off)
                16'd0: rdata[NUM_LEDG-1:0] = ledg_q;
                16'd1: rdata[NUM_LEDR-1:0] = ledr_q;
                16'd2: rdata[NUM_KEY-1:0]  = ~kstable_q;
                16'd3: rdata[NUM_KEY-1:0]  = evt_q;
                16'd4: rdata[NUM_KEY-1:0]  = mask_q;
                16'd5: rdata[NUM_SW-1:0]   = swsync2_q;
`ifdef BOARD_IO_CTRL_HEXDEC_EN
                16'd6: rdata[NUM_HEX-1:0]  = hexmode_q;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ledg_q    <= '0;
            ledr_q    <= '0;
            ksync1_q  <= '1;
            ksync2_q  <= '1;
            swsync1_q <= '0;
            swsync2_q <= '0;
            kstable_q <= '1;
            cnt_q     <= '0;
            evt_q     <= '0;
            mask_q    <= '0;
            hex_q     <= '1;
`ifdef BOARD_IO_CTRL_HEXDEC_EN
            hexmode_q <= '0;
`endif
        end else begin
            ledg_q    <= ledg_d;
            ledr_q    <= ledr_d;
            ksync1_q  <= key;
            ksync2_q  <= ksync1_q;
            swsync1_q <= sw;
            swsync2_q <= swsync1_q;
            kstable_q <= kstable_d;
            cnt_q     <= cnt_d;
            evt_q     <= evt_d;
            mask_q    <= mask_d;
            hex_q     <= hex_d;
`ifdef BOARD_IO_CTRL_HEXDEC_EN
            hexmode_q <= hexmode_d;
`endif
        end
    end

    assign io.din = rdata;
    assign ledg   = ledg_q;
    assign ledr   = ledr_q;
    assign hex    = hex_q;
    assign irq    = |(evt_q & mask_q);
endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised successor of the evaluation-board I/O peripheral on the J1 I/O bus (`if_io.slave`).
- Widths of the green LED, red LED, switch, key and seven-segment-digit groups are set by parameters.
- Adds LED readback, synchronised switches, debounced keys, sticky key-press events with an interrupt mask, and a level interrupt output.
- Sits beside the other I/O slaves; its read data is OR-combined onto the shared `io.din` bus.

Parameters:
- BASE, 16'h0000, base I/O address of the register block.
- NUM_LEDG, 8, green LED count (1..16).
- NUM_LEDR, 10, red LED count (1..16).
- NUM_SW, 10, toggle switch count (1..16).
- NUM_KEY, 4, push-button count (1..16).
- NUM_HEX, 4, seven-segment digit count (1..8).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key change is accepted (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- key  input  NUM_KEY  raw push buttons, active low (0 = pressed), asynchronous to clk.
- sw  input  NUM_SW  raw toggle switches, asynchronous to clk.
- hex  output  [0:NUM_HEX-1][6:0]  segment drive, active low (1 = segment off).
- ledg  output  NUM_LEDG  green LEDs, 1 = on.
- ledr  output  NUM_LEDR  red LEDs, 1 = on.
- irq  output  1  level interrupt, high while any unmasked key event is pending.
- io  if_io.slave  -  J1 I/O bus: addr, dout (CPU write data, 16 bit), din (read data, 16 bit), rd, wr.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - ledg = 0, ledr = 0, hex = all ones (blank).
  - key synchronisers = all ones (released); switch synchronisers = 0.
  - key stable state = released, debounce counters = 0, events = 0, mask = 0, hexmode = 0.
  - irq = 0.
- Register map (offset from BASE; R = read, W = write):
  - 0 LEDG RW
  - 1 LEDR RW
  - 2 KEYSTAT R: debounced state, 1 = pressed
  - 3 KEYEVT R / W1C
  - 4 KEYMASK RW
  - 5 SW R: synchronised switches
  - 6 HEXMODE RW (optional feature)
  - 8..8+NUM_HEX-1 HEX digit 0..NUM_HEX-1 W: dout[6:0] with 1 = segment lit
- Writes:
  - Take effect at the clk edge where wr = 1 and addr matches; only the low-order register bits are used.
  - Writes to read-only or unmapped offsets are ignored.
- HEX write: hex[i] <= ~dout[6:0]. hex reads back as 0.
- Reads:
  - Combinational. din = 0 unless rd = 1 and addr matches a readable offset.
  - Unimplemented bits read 0. This is mandatory for the OR bus.
  - LEDG and LEDR read back the current register value.
- Synchronisers: key and sw each pass through a 2-flop synchroniser; a pin change is visible at the synchroniser output 2 cycles later.
- Debounce, per key, with an independent counter of width clog2(DEBOUNCE_CYCLES+1):
  - If the synchronised value equals the stable state, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable state takes the synchronised value and the counter clears.
  - Net effect: the change is accepted after DEBOUNCE_CYCLES consecutive differing cycles.
  - A bounce back to the stable value at any point restarts the count.
- Events:
  - KEYEVT[i] is set in the same cycle that the stable state of key i goes released -> pressed. Release does not set an event.
  - A write to KEYEVT clears the bits where dout = 1.
  - A simultaneous set and clear on the same bit leaves the bit set (set wins).
- irq = |(KEYEVT & KEYMASK), combinational from registers. It has no latency beyond the register update.
- Reset mid-debounce: the counter is discarded and the key returns to released. A key held through reset generates an event DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- rd and wr asserted in the same cycle: the read returns the pre-write value and the write applies at the edge.

Optional Feature:
- Macro: BOARD_IO_CTRL_HEXDEC_EN.
- Defined:
  - HEXMODE[NUM_HEX-1:0] is RW and resets to 0.
  - When HEXMODE[i] = 1, a write to HEX digit i decodes dout[3:0] as a hex nibble 0-F to standard 7-segment codes at write time.
  - Example: 0 -> 7'h3F lit, so hex[i] = 7'h40; A -> 7'h77 lit.
  - dout[6:4] is ignored in decode mode. Changing HEXMODE does not re-decode digits already written.
- Undefined: offset 6 reads 0, writes are ignored, and all HEX writes are raw.

Test Plan (defaults except DEBOUNCE_CYCLES = 16):
- Reset, then read every offset with rd = 1 -> LEDG/LEDR/KEYSTAT/KEYEVT/KEYMASK = 0, SW = synchronised sw, hex = 7'h7F on all digits, irq = 0. With rd = 0, din = 0 at all times.
- Write LEDG = 16'hFFA5, LEDR = 16'hFFFF -> ledg = 8'hA5, ledr = 10'h3FF; readback gives 16'h00A5 and 16'h03FF. Write HEX2 = 16'h0006 -> hex[2] = 7'h79, other digits unchanged.
- Drive key[1] = 0 with bounces (0 for 5 cycles, 1 for 1 cycle, then 0 steady) -> KEYSTAT bit1 and KEYEVT bit1 set exactly 2 + 16 cycles after the last bounce, not earlier. Release -> KEYSTAT clears, KEYEVT stays 1.
- With KEYEVT = 4'b0010: write KEYMASK = 4'b0010 -> irq = 1 from the next cycle. Write KEYEVT = 4'b0010 -> irq = 0. Repeat the clear on the exact cycle of a new key[1] press acceptance -> bit stays 1, irq stays 1.
- Assert reset while a key counter is at 10 -> after reset, KEYSTAT = 0 and KEYEVT = 0. Key still held -> event 18 cycles after reset deasserts.
- With BOARD_IO_CTRL_HEXDEC_EN: HEXMODE = 4'b0001, write HEX0 = 16'h00FA -> hex[0] = ~7'h77 = 7'h08. Without the macro the same write gives hex[0] = 7'h05, and HEXMODE reads 0.
